ldpcenc_cu_v2: RTL

- Parametrised, second-generation controller unit for the Wi-Fi LDPC encoder.
- Sequences one codeword through four phases: message beats in, a one-cycle turnaround, parity beats out.
- Drives the datapath counters, the accumulator clear and the input data pipeline.
- Adds over the previous generation: configurable beat width, downstream backpressure in the parity phase, end-of-packet marking, mode/sop error flags and a packet counter.

---
 rtl/ldpcenc_cu_v2_if.sv | 29 ++
 rtl/ldpcenc_cu_v2.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ldpcenc_cu_v2_if.sv
// Stream interface for the LDPC encoder controller.
//   Input side : vld_in, sop_in, mode_in, data_in go from the source to the controller.
//                rdy_in goes from the controller to the source.
//   Output side: rdy_out goes from the sink to the controller.
//                vld_out, sop_out, eop_out go from the controller to the sink.
// The master modport is the environment (source plus sink). The slave modport is the controller.
interface ldpcenc_cu_v2_if #(
  parameter int DW = 27
);
  logic          vld_in;
  logic          sop_in;
  logic [3:0]    mode_in;
  logic [DW-1:0] data_in;
  logic          rdy_in;
  logic          rdy_out;
  logic          vld_out;
  logic          sop_out;
  logic          eop_out;

  modport master (
    output vld_in, sop_in, mode_in, data_in, rdy_out,
    input  rdy_in, vld_out, sop_out, eop_out
  );

  modport slave (
    input  vld_in, sop_in, mode_in, data_in, rdy_out,
    output rdy_in, vld_out, sop_out, eop_out
  );
endinterface

// File: rtl/ldpcenc_cu_v2.sv
// Controller unit for the Wi-Fi LDPC encoder, second generation.
// It sequences one codeword at a time through four states:
//   IDLE : waits for a start-of-packet beat
//   MSG  : accepts the message beats
//   WAIT : one turnaround cycle
//   PRT  : issues the parity beats; rdy_out can stall this phase
// Ports:
//   clk, srst    : clock and synchronous active-high reset
//   bus (slave)  : input and output stream handshake (see ldpcenc_cu_v2_if)
//   state        : current FSM state (IDLE=0, MSG=1, WAIT=2, PRT=3)
//   mode         : mode latched at sop
//   cnt_vld_max  : latched mode[3:2] (beats per symbol minus 1)
//   cnt_sym      : symbol counter for the datapath
//   cnt_vld      : beat-within-symbol counter for the datapath
//   clr_acc      : accumulator clear, one cycle after the sop beat is accepted
//   vld          : registered valid of an accepted beat
//   data_r1..3   : three-stage input data pipeline
//   err_mode     : one-cycle pulse, sop carried an illegal mode
//   err_sop      : one-cycle pulse, sop arrived inside the message phase
//   pkt_cnt      : count of completed packets, wraps around
module ldpcenc_cu_v2 #(
  parameter int DW     = 27,
  parameter int NB_MAX = 3,
  parameter int PCW    = 16
) (
  input  logic                clk,
  input  logic                srst,
  ldpcenc_cu_v2_if.slave      bus,
  output logic [1:0]          state,
  output logic [3:0]          mode,
  output logic [4:0]          cnt_sym,
  output logic [1:0]          cnt_vld,
  output logic [1:0]          cnt_vld_max,
  output logic                clr_acc,
  output logic                vld,
  output logic [DW-1:0]       data_r1,
  output logic [DW-1:0]       data_r2,
  output logic [DW-1:0]       data_r3,
  output logic                err_mode,
  output logic                err_sop,
  output logic [PCW-1:0]      pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    WAIT = 2'd2,
    PRT  = 2'd3
  } state_t;

  localparam logic [2:0] NB_MAX_W = 3'(NB_MAX);

  state_t     cur, nxt;
  logic [4:0] msg_len, prt_len;
  logic       vld_out_r, sop_out_r, eop_out_r;

  // Index of the last message symbol for each rate. The parity length
  // makes the codeword 24 symbols long in total (indices 0..23).
  function automatic logic [4:0] msg_len_of(input logic [1:0] rate);
    case (rate)
      2'd0:    return 5'd11;
      2'd1:    return 5'd15;
      2'd2:    return 5'd17;
      default: return 5'd19;
    endcase
  endfunction

  logic       rdy_int, accept, mode_ok, start, bad_mode, msg_beat, issue;
  logic       advance, sym_end, msg_last, prt_last;
  logic [1:0] vld_max_eff;

  always_comb begin
    rdy_int  = (cur == IDLE) || (cur == MSG);
    accept   = bus.vld_in && rdy_int;
    mode_ok  = {1'b0, bus.mode_in[3:2]} < NB_MAX_W;
    start    = (cur == IDLE) && accept && bus.sop_in && mode_ok;
    bad_mode = (cur == IDLE) && accept && bus.sop_in && !mode_ok;
    msg_beat = (cur == MSG) && accept;
    issue    = (cur == PRT) && bus.rdy_out;
    advance  = start || msg_beat || issue;
    // The sop beat is already the first message beat. It has to wrap
    // against the incoming mode because cnt_vld_max is not latched yet.
    vld_max_eff = start ? bus.mode_in[3:2] : cnt_vld_max;
    sym_end     = (cnt_vld == vld_max_eff);
    msg_last    = msg_beat && sym_end && (cnt_sym == msg_len);
    prt_last    = issue && sym_end && (cnt_sym == prt_len);
  end

  // State register
  // NOTE: sequential logic uses non-blocking assignments only. Every flop
  // then samples pre-edge values, whatever order the always blocks run in.
  always_ff @(posedge clk) begin
    if (srst) cur <= IDLE;
    else      cur <= nxt;
  end

  // Next-state logic
  // NOTE: nxt gets a default before the case statement. Without it, any path
  // that skips the assignment would infer a latch.
  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE: if (start)    nxt = MSG;
      MSG:  if (msg_last) nxt = WAIT;
      WAIT:               nxt = PRT;
      PRT:  if (prt_last) nxt = IDLE;
      default:            nxt = IDLE;
    endcase
  end

  // Configuration captured at sop. An illegal sop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (srst) begin
      mode        <= '0;
      cnt_vld_max <= '0;
      msg_len     <= '0;
      prt_len     <= '0;
    end else if (start) begin
      mode        <= bus.mode_in;
      cnt_vld_max <= bus.mode_in[3:2];
      msg_len     <= msg_len_of(bus.mode_in[1:0]);
      prt_len     <= 5'd22 - msg_len_of(bus.mode_in[1:0]);
    end
  end

  // Symbol and beat counters. They return to 0 on each phase exit, so they
  // stay at 0 in IDLE and WAIT. A parity stall freezes them because issue is low.
  always_ff @(posedge clk) begin
    if (srst || msg_last || prt_last) begin
      cnt_sym <= '0;
      cnt_vld <= '0;
    end else if (advance) begin
      if (sym_end) begin
        cnt_vld <= '0;
        cnt_sym <= cnt_sym + 5'd1;
      end else begin
        cnt_vld <= cnt_vld + 2'd1;
      end
    end
  end

  // Input data pipeline. It shifts only on accepted message beats.
  // NOTE: these are plain pipeline flops, not a memory array, so they are
  // cleared by reset together with the other registered outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      data_r1 <= '0;
      data_r2 <= '0;
      data_r3 <= '0;
    end else if (start || msg_beat) begin
      data_r1 <= bus.data_in;
      data_r2 <= data_r1;
      data_r3 <= data_r2;
    end
  end

  // Control pulses, output stream flags and the packet counter
  always_ff @(posedge clk) begin
    if (srst) begin
      vld       <= 1'b0;
      clr_acc   <= 1'b0;
      sop_out_r <= 1'b0;
      vld_out_r <= 1'b0;
      eop_out_r <= 1'b0;
      err_mode  <= 1'b0;
      err_sop   <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      vld       <= start || msg_beat;
      clr_acc   <= start;
      // clr_acc is the sop beat delayed by one cycle, so this lines up
      // sop_out with the first message vld_out.
      sop_out_r <= clr_acc;
      unique case (cur)
        MSG, WAIT: vld_out_r <= vld;
        PRT:       vld_out_r <= issue;
        default:   vld_out_r <= 1'b0;
      endcase
      eop_out_r <= prt_last;
      err_mode  <= bad_mode;
      err_sop   <= msg_beat && bus.sop_in;
      if (prt_last) pkt_cnt <= pkt_cnt + PCW'(1);
    end
  end

  assign state       = cur;
  assign bus.rdy_in  = rdy_int;
  assign bus.vld_out = vld_out_r;
  assign bus.sop_out = sop_out_r;
  assign bus.eop_out = eop_out_r;

endmodule
